sfx_scheduler: RTL

SFX_SCHEDULER -- requirements
Module: sfx_scheduler

---
 rtl/sfx_scheduler_pkg.sv | 36 +++
 rtl/sfx_scheduler_if.sv | 22 ++
 rtl/sfx_rom.sv | 56 +++++
 rtl/sfx_scheduler.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/sfx_scheduler_pkg.sv
// Shared definitions for the sound-effect scheduler: state and source encodings,
// buzzer half-period divider constants and effect priority.
package sfx_scheduler_pkg;

   typedef enum logic [1:0] {
      StIdle     = 2'd0,
      StBgm      = 2'd1,
      StFx       = 2'd2,
      StOverDone = 2'd3
   } state_e;

   typedef enum logic [2:0] {
      SrcNone  = 3'd0,
      SrcBgm   = 3'd1,
      SrcLock  = 3'd2,
      SrcClear = 3'd3,
      SrcOver  = 3'd4
   } src_e;

   // 100 MHz / f / 2, integer arithmetic
   localparam logic [21:0] DivC4 = 22'd191570;
   localparam logic [21:0] DivE4 = 22'd151515;
   localparam logic [21:0] DivG4 = 22'd127551;
   localparam logic [21:0] DivC5 = 22'd95419;
   localparam logic [21:0] DivE5 = 22'd75757;

   function automatic logic [1:0] src_prio(src_e s);
      case (s)
         SrcOver:  return 2'd3;
         SrcClear: return 2'd2;
         SrcLock:  return 2'd1;
         default:  return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/sfx_scheduler_if.sv
// Request/step inputs and buzzer outputs of the sound-effect scheduler.
interface sfx_scheduler_if;
   logic        step;
   logic        req_over;
   logic        req_clear;
   logic [2:0]  clear_lines;
   logic        req_lock;
   logic        bgm_en;
   logic [21:0] note_div;
   logic [2:0]  src;
   logic        busy;

   modport master (
      output step, req_over, req_clear, clear_lines, req_lock, bgm_en,
      input  note_div, src, busy
   );

   modport slave (
      input  step, req_over, req_clear, clear_lines, req_lock, bgm_en,
      output note_div, src, busy
   );
endinterface

// File: rtl/sfx_rom.sv
// Combinational note table: maps (source, index) to a buzzer divider; 0 = silent
// or out of range.
module sfx_rom
   import sfx_scheduler_pkg::*;
#(
   parameter int unsigned STEP_MAX = 8
) (
   input  src_e        src,
   input  logic [2:0]  idx,
   output logic [21:0] div
);

   always_comb begin
      div = '0;
      case (src)
         SrcBgm: begin
            if (32'(idx) < STEP_MAX) begin
               case (idx)
                  3'd0:    div = DivC4;
                  3'd1:    div = DivE4;
                  3'd2:    div = DivG4;
                  3'd3:    div = DivE4;
                  3'd4:    div = DivC4;
                  3'd5:    div = DivG4;
                  3'd6:    div = DivC5;
                  default: div = DivG4;
               endcase
            end
         end
         SrcLock: begin
            if (idx == 3'd0) div = DivC5;
         end
         SrcClear: begin
            case (idx)
               3'd0:    div = DivC4;
               3'd1:    div = DivE4;
               3'd2:    div = DivG4;
               3'd3:    div = DivC5;
               3'd4:    div = DivE5;
               default: div = '0;
            endcase
         end
         SrcOver: begin
            // Index 3 is the closing rest.
            case (idx)
               3'd0:    div = DivG4;
               3'd1:    div = DivE4;
               3'd2:    div = DivC4;
               default: div = '0;
            endcase
         end
         default: div = '0;
      endcase
   end

endmodule

// File: rtl/sfx_scheduler.sv
// Buzzer scheduler: plays a looping background tune and preempts it with
// prioritised lock / line-clear / game-over jingles.
module sfx_scheduler
   import sfx_scheduler_pkg::*;
#(
   parameter int unsigned STEP_MAX = 8
) (
   input logic            clk,
   input logic            rst,
   sfx_scheduler_if.slave bus
);

   state_e      state_q, state_d;
   src_e        fx_src_q, fx_src_d, top, src_q, src_d;
   logic [2:0]  fx_idx_q, fx_idx_d, fx_last_q, fx_last_d;
   logic [2:0]  bgm_idx_q, bgm_idx_d, lines_q, lines_d, rom_idx;
   logic        pend_over_q, pend_clear_q, pend_lock_q;
   logic        pend_over_d, pend_clear_d, pend_lock_d;
   logic        grant, busy_q, busy_d;
   logic [21:0] note_div_q, note_div_d;

   always_comb begin
      if (pend_over_q)       top = SrcOver;
      else if (pend_clear_q) top = SrcClear;
      else if (pend_lock_q)  top = SrcLock;
      else                   top = SrcNone;
   end

   always_comb begin
      state_d   = state_q;
      fx_src_d  = fx_src_q;
      fx_idx_d  = fx_idx_q;
      fx_last_d = fx_last_q;
      bgm_idx_d = bgm_idx_q;
      grant     = 1'b0;
      case (state_q)
         StIdle: begin
            bgm_idx_d = '0;
            if (top != SrcNone) grant = 1'b1;
            else if (bus.bgm_en) state_d = StBgm;
         end
         StBgm: begin
            if (top != SrcNone) begin
               grant = 1'b1;
            end else if (!bus.bgm_en) begin
               state_d   = StIdle;
               bgm_idx_d = '0;
            end else if (bus.step) begin
               bgm_idx_d = (32'(bgm_idx_q) == STEP_MAX - 1) ? 3'd0 : bgm_idx_q + 3'd1;
            end
         end
         StFx: begin
            if (src_prio(top) > src_prio(fx_src_q)) begin
               grant = 1'b1;
            end else if (bus.step) begin
               if (fx_idx_q != fx_last_q) fx_idx_d = fx_idx_q + 3'd1;
               else if (fx_src_q == SrcOver) state_d = StOverDone;
               else if (top != SrcNone) grant = 1'b1;
               else state_d = bus.bgm_en ? StBgm : StIdle;
            end
         end
         default: ;
      endcase
      // A grant swallows any step of the same cycle so the first note lasts a full period.
      if (grant) begin
         state_d  = StFx;
         fx_src_d = top;
         fx_idx_d = '0;
         case (top)
            SrcOver:  fx_last_d = 3'd3;
            SrcClear: fx_last_d = lines_q;
            default:  fx_last_d = 3'd0;
         endcase
      end
   end

   always_comb begin
      if (bus.clear_lines == 3'd0)     lines_d = 3'd1;
      else if (bus.clear_lines > 3'd4) lines_d = 3'd4;
      else                             lines_d = bus.clear_lines;
   end

   // Any grant is the top request, so it always supersedes a pending lock.
   assign pend_over_d  = (state_q != StOverDone) &&
                         ((pend_over_q && !(grant && top == SrcOver)) || bus.req_over);
   assign pend_clear_d = (state_q != StOverDone) &&
                         ((pend_clear_q && !(grant && top >= SrcClear)) || bus.req_clear);
   assign pend_lock_d  = (state_q != StOverDone) &&
                         ((pend_lock_q && !grant) || bus.req_lock);

   always_comb begin
      case (state_d)
         StFx:    src_d = fx_src_d;
         StBgm:   src_d = SrcBgm;
         default: src_d = SrcNone;
      endcase
   end

   assign rom_idx = (state_d == StFx) ? fx_idx_d : bgm_idx_d;
   assign busy_d  = (state_d == StFx);

   sfx_rom #(
      .STEP_MAX(STEP_MAX)
   ) u_rom (
      .src(src_d),
      .idx(rom_idx),
      .div(note_div_d)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         fx_src_q     <= SrcNone;
         fx_idx_q     <= '0;
         fx_last_q    <= '0;
         bgm_idx_q    <= '0;
         lines_q      <= 3'd1;
         pend_over_q  <= 1'b0;
         pend_clear_q <= 1'b0;
         pend_lock_q  <= 1'b0;
         src_q        <= SrcNone;
         note_div_q   <= '0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         fx_src_q     <= fx_src_d;
         fx_idx_q     <= fx_idx_d;
         fx_last_q    <= fx_last_d;
         bgm_idx_q    <= bgm_idx_d;
         if (bus.req_clear && state_q != StOverDone) lines_q <= lines_d;
         pend_over_q  <= pend_over_d;
         pend_clear_q <= pend_clear_d;
         pend_lock_q  <= pend_lock_d;
         src_q        <= src_d;
         note_div_q   <= note_div_d;
         busy_q       <= busy_d;
      end
   end

   assign bus.note_div = note_div_q;
   assign bus.src      = src_q;
   assign bus.busy     = busy_q;

endmodule
